uart_tx: RTL

// UART serializer: accepts one byte per handshake, emits start bit, 8 data bits LSB first,

---
 rtl/uart_tx_pkg.sv | 33 +++
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx_baud_gen.sv | 33 +++
 rtl/uart_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_pkg
// Brief   : Shared parity coding, FSM states and parity helpers for uart_tx.
// Revision: 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    typedef logic [1:0] parity_t;

    // Same coding as the receiver side so a TX/RX pair with equal settings round-trips.
    localparam parity_t c_parity_none = 2'd0;
    localparam parity_t c_parity_odd  = 2'd1;
    localparam parity_t c_parity_even = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic logic parity_enabled(input parity_t ptype);
        return (ptype == c_parity_odd) || (ptype == c_parity_even);
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input parity_t ptype);
        return (ptype == c_parity_odd) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_if
// Brief   : Byte handshake and serial line bundle of the UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic       tx_start;
    logic [7:0] tx_data;
    parity_t    parity_type;
    logic       serial_data_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start, tx_data, parity_type,
        input  serial_data_out, tx_busy, tx_done
    );

    modport slave (
        input  tx_start, tx_data, parity_type,
        output serial_data_out, tx_busy, tx_done
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_baud_gen.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_baud_gen
// Brief   : Bit-period counter; o_bit_tick marks the last cycle of each bit.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    output logic      o_bit_tick
);

    localparam int                 c_cnt_w = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Reloading on every terminal count keeps bit boundaries drift-free.
    always_ff @(posedge clk) begin
        if (!rst || i_clear || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_tick = (r_cnt == c_last) && !i_clear;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Brief   : UART serializer: start, 8 data bits LSB first, optional parity, stop bit(s).
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int STOP_BITS    = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_tx_if.slave  bus
);

    localparam logic c_last_stop = 1'(STOP_BITS - 1);

    tx_state_t  r_state,     w_state_nxt;
    logic [7:0] r_shift,     w_shift_nxt;
    logic [2:0] r_idx,       w_idx_nxt;
    logic       r_stop_cnt,  w_stop_cnt_nxt;
    logic       r_par_en,    w_par_en_nxt;
    logic       r_par_bit,   w_par_bit_nxt;
    logic       r_line,      w_line_nxt;
    logic       r_done,      w_done_nxt;
    logic       w_clear;
    logic       w_tick;

    // Held clear while idle so the start bit begins a fresh full-length period.
    uart_tx_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .o_bit_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_line     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_idx      <= w_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_line     <= w_line_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_idx_nxt      = r_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_line_nxt     = r_line;
        w_done_nxt     = 1'b0;
        w_clear        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_clear    = 1'b1;
                w_line_nxt = 1'b1;
                if (bus.tx_start) begin
                    w_shift_nxt   = bus.tx_data;
                    w_par_en_nxt  = parity_enabled(bus.parity_type);
                    w_par_bit_nxt = parity_bit(bus.tx_data, bus.parity_type);
                    w_idx_nxt     = '0;
                    w_line_nxt    = 1'b0;
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_line_nxt  = r_shift[0];
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_idx == 3'd7) begin
                        w_stop_cnt_nxt = 1'b0;
                        if (r_par_en) begin
                            w_line_nxt  = r_par_bit;
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_line_nxt  = 1'b1;
                            w_state_nxt = ST_STOP;
                        end
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_line_nxt  = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_stop_cnt_nxt = 1'b0;
                    w_line_nxt     = 1'b1;
                    w_state_nxt    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == c_last_stop) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_line_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.serial_data_out = r_line;
    assign bus.tx_busy         = (r_state != ST_IDLE);
    assign bus.tx_done         = r_done;

endmodule
`default_nettype wire
